// File: rtl/wb_master_arbiter.sv
// ============================================================================
// Module   : wb_master_arbiter
// Purpose  : Round-robin sharing of one Wishbone classic master port between
//            NUM_REQ command-interface requesters, with rty retry and err status.
// Options  : `define WB_ARB_TIMEOUT_EN adds a BUS response timeout of TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst_n,
    input  logic [NUM_REQ-1:0]        req_start,
    input  logic [NUM_REQ*AW-1:0]     req_address,
    input  logic [NUM_REQ*(DW/8)-1:0] req_selection,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DW-1:0]     req_data_wr,
    output logic [NUM_REQ*DW-1:0]     req_data_rd,
    output logic [NUM_REQ-1:0]        req_active,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [AW-1:0]             wb_adr_o,
    output logic [DW-1:0]             wb_dat_o,
    output logic [DW/8-1:0]           wb_sel_o,
    output logic                      wb_we_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic [2:0]                wb_cti_o,
    output logic [1:0]                wb_bte_o,
    input  logic [DW-1:0]             wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    input  logic                      wb_rty_i,
    output logic [NUM_REQ-1:0]        grant
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_RETRY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  pending_q, pending_d;
    logic [NUM_REQ-1:0]  active_q, active_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic                cyc_q, cyc_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic                we_q, we_d;

    logic [AW-1:0]       slot_adr_q [NUM_REQ];
    logic [AW-1:0]       slot_adr_d [NUM_REQ];
    logic [DW-1:0]       slot_dat_q [NUM_REQ];
    logic [DW-1:0]       slot_dat_d [NUM_REQ];
    logic [SW-1:0]       slot_sel_q [NUM_REQ];
    logic [SW-1:0]       slot_sel_d [NUM_REQ];
    logic [NUM_REQ-1:0]  slot_we_q, slot_we_d;
    logic [DW-1:0]       rdata_q [NUM_REQ];
    logic [DW-1:0]       rdata_d [NUM_REQ];

`ifdef WB_ARB_TIMEOUT_EN
    logic [TW-1:0]       tmo_q, tmo_d;
`endif

    logic [NUM_REQ-1:0]  w_accept;
    logic                w_found;
    logic [IW-1:0]       w_win;
    logic [IW-1:0]       w_idx;
    logic                w_fin;
    logic                w_fin_err;

    // A requester holding an outstanding command ignores further strobes.
    assign w_accept = req_start & ~active_q & ~pending_q;

    // Search upward from the previous owner so every pending requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (!w_found && pending_q[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        owner_d    = owner_q;
        pending_d  = pending_q;
        active_d   = active_q & ~done_q;
        done_d     = '0;
        err_d      = '0;
        retry_d    = retry_q;
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        slot_adr_d = slot_adr_q;
        slot_dat_d = slot_dat_q;
        slot_sel_d = slot_sel_q;
        slot_we_d  = slot_we_q;
        rdata_d    = rdata_q;
        w_fin      = 1'b0;
        w_fin_err  = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif

        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                slot_adr_d[i] = req_address[i*AW +: AW];
                slot_dat_d[i] = req_data_wr[i*DW +: DW];
                slot_sel_d[i] = req_selection[i*SW +: SW];
                slot_we_d[i]  = req_write[i];
                pending_d[i]  = 1'b1;
                active_d[i]   = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d = NUM_REQ'(1) << w_win;
                    last_d  = w_win;
                    owner_d = w_win;
                    adr_d   = slot_adr_q[w_win];
                    dat_d   = slot_dat_q[w_win];
                    sel_d   = slot_sel_q[w_win];
                    we_d    = slot_we_q[w_win];
                    cyc_d   = 1'b1;
                    retry_d = '0;
                    state_d = S_BUS;
`ifdef WB_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_BUS: begin
                if (wb_err_i) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else if (wb_ack_i) begin
                    w_fin = 1'b1;
                    if (!we_q) begin
                        rdata_d[owner_q] = wb_dat_i;
                    end
                end else if (wb_rty_i) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        cyc_d   = 1'b0;
                        state_d = S_RETRY;
                    end else begin
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end
                end else begin
`ifdef WB_ARB_TIMEOUT_EN
                    if (tmo_q == TMO_LAST) begin
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
`endif
                end
            end
            S_RETRY: begin
                cyc_d   = 1'b1;
                state_d = S_BUS;
`ifdef WB_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            default: begin
                cyc_d   = 1'b0;
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        // Active stays up through the done cycle; it drops via the done_q term above.
        if (w_fin) begin
            cyc_d              = 1'b0;
            done_d[owner_q]    = 1'b1;
            err_d[owner_q]     = w_fin_err;
            pending_d[owner_q] = 1'b0;
            grant_d            = '0;
            retry_d            = '0;
            state_d            = S_IDLE;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            owner_q   <= '0;
            pending_q <= '0;
            active_q  <= '0;
            done_q    <= '0;
            err_q     <= '0;
            retry_q   <= '0;
            cyc_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            slot_we_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_adr_q[i] <= '0;
                slot_dat_q[i] <= '0;
                slot_sel_q[i] <= '0;
                rdata_q[i]    <= '0;
            end
`ifdef WB_ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            done_q     <= done_d;
            err_q      <= err_d;
            retry_q    <= retry_d;
            cyc_q      <= cyc_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            slot_we_q  <= slot_we_d;
            slot_adr_q <= slot_adr_d;
            slot_dat_q <= slot_dat_d;
            slot_sel_q <= slot_sel_d;
            rdata_q    <= rdata_d;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;
    assign grant      = grant_q;
    assign req_active = active_q;
    assign req_done   = done_q;
    assign req_err    = err_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdata
        assign req_data_rd[gi*DW +: DW] = rdata_q[gi];
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
// ============================================================================
// Module   : tb_wb_master_arbiter
// Purpose  : Directed self-checking bench for wb_master_arbiter (2 requesters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_master_arbiter;

    localparam int NR    = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAXR  = 4;
    localparam int TMO   = 64;
    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_RTY = 2;

    logic              wb_clk = 1'b0;
    logic              wb_rst_n;
    logic [NR-1:0]     req_start;
    logic [NR*AW-1:0]  req_address;
    logic [NR*4-1:0]   req_selection;
    logic [NR-1:0]     req_write;
    logic [NR*DW-1:0]  req_data_wr;
    logic [NR*DW-1:0]  req_data_rd;
    logic [NR-1:0]     req_active;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic [AW-1:0]     wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [3:0]        wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic [DW-1:0]     wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_rty_i;
    logic [NR-1:0]     grant;

    int n_cmp     = 0;
    int n_err     = 0;
    int done_cnt  = 0;
    int cyc_rises = 0;
    int bad_owner = 0;
    logic cyc_prev = 1'b0;

    wb_master_arbiter #(
        .NUM_REQ   (NR),
        .AW        (AW),
        .DW        (DW),
        .MAX_RETRY (MAXR),
        .TIMEOUT   (TMO)
    ) u_dut (
        .wb_clk        (wb_clk),
        .wb_rst_n      (wb_rst_n),
        .req_start     (req_start),
        .req_address   (req_address),
        .req_selection (req_selection),
        .req_write     (req_write),
        .req_data_wr   (req_data_wr),
        .req_data_rd   (req_data_rd),
        .req_active    (req_active),
        .req_done      (req_done),
        .req_err       (req_err),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_we_o       (wb_we_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_cti_o      (wb_cti_o),
        .wb_bte_o      (wb_bte_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i),
        .wb_rty_i      (wb_rty_i),
        .grant         (grant)
    );

    always #5 wb_clk = ~wb_clk;

    // Bus-wide invariants: a live cycle has exactly one owner and stb tracks cyc.
    always @(negedge wb_clk) begin
        done_cnt <= done_cnt + $countones(req_done);
        if (wb_cyc_o && !cyc_prev) cyc_rises <= cyc_rises + 1;
        if ((wb_cyc_o && ($countones(grant) != 1)) || (wb_cyc_o != wb_stb_o) ||
            ($countones(req_done) > 1))
            bad_owner <= bad_owner + 1;
        cyc_prev <= wb_cyc_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not reach its summary in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic set_cmd(input int idx, input logic [31:0] adr, input logic [3:0] sel,
                           input logic we, input logic [31:0] dat);
        req_address[idx*AW +: AW]  = adr;
        req_selection[idx*4 +: 4]  = sel;
        req_write[idx]             = we;
        req_data_wr[idx*DW +: DW]  = dat;
    endtask

    task automatic issue(input logic [NR-1:0] mask);
        req_start = mask;
        tick();
        req_start = '0;
    endtask

    task automatic wait_cyc(output int n);
        n = 0;
        while (!wb_cyc_o && n < 100) begin
            tick();
            n++;
        end
        check_eq("cyc_up", wb_cyc_o, 1'b1);
    endtask

    task automatic slave(input int kind, input int dly, input logic [31:0] d,
                         output logic [NR-1:0] g);
        int n;
        wait_cyc(n);
        g = grant;
        repeat (dly) tick();
        wb_dat_i = d;
        case (kind)
            K_ACK:   wb_ack_i = 1'b1;
            K_ERR:   wb_err_i = 1'b1;
            default: wb_rty_i = 1'b1;
        endcase
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
    endtask

    initial begin
        logic [NR-1:0] g;
        int n;
        int d0;
        int c0;

        wb_rst_n      = 1'b0;
        req_start     = '0;
        req_address   = '0;
        req_selection = '0;
        req_write     = '0;
        req_data_wr   = '0;
        wb_dat_i      = '0;
        wb_ack_i      = 1'b0;
        wb_err_i      = 1'b0;
        wb_rty_i      = 1'b0;

        repeat (3) tick();
        check_eq("rst_cyc",    wb_cyc_o,    1'b0);
        check_eq("rst_stb",    wb_stb_o,    1'b0);
        check_eq("rst_grant",  grant,       2'b00);
        check_eq("rst_done",   req_done,    2'b00);
        check_eq("rst_active", req_active,  2'b00);
        check_eq("rst_err",    req_err,     2'b00);
        check_eq("rst_rdata",  req_data_rd, 64'h0);
        check_eq("rst_cti",    {wb_cti_o, wb_bte_o}, 5'b0);
        wb_rst_n = 1'b1;
        tick();

        // Single write from requester 0, slave acks after two wait cycles
        set_cmd(0, 32'h9000_0000, 4'hF, 1'b1, 32'hDEAD_BEEF);
        issue(2'b01);
        check_eq("wr_active", req_active, 2'b01);
        check_eq("wr_cyc_lat", wb_cyc_o, 1'b0);
        tick();
        check_eq("wr_cyc",   wb_cyc_o, 1'b1);
        check_eq("wr_stb",   wb_stb_o, 1'b1);
        check_eq("wr_adr",   wb_adr_o, 32'h9000_0000);
        check_eq("wr_dat",   wb_dat_o, 32'hDEAD_BEEF);
        check_eq("wr_sel",   wb_sel_o, 4'hF);
        check_eq("wr_we",    wb_we_o,  1'b1);
        check_eq("wr_grant", grant,    2'b01);
        tick();
        tick();
        check_eq("wr_adr_hold", wb_adr_o, 32'h9000_0000);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check_eq("wr_done",      req_done,   2'b01);
        check_eq("wr_err",       req_err,    2'b00);
        check_eq("wr_cyc_drop",  wb_cyc_o,   1'b0);
        check_eq("wr_grant_idle", grant,     2'b00);
        check_eq("wr_active_done", req_active, 2'b01);
        tick();
        check_eq("wr_done_pulse", req_done,   2'b00);
        check_eq("wr_active_clr", req_active, 2'b00);

        // Read from requester 1
        set_cmd(1, 32'h9000_0004, 4'hF, 1'b0, 32'h0);
        issue(2'b10);
        slave(K_ACK, 0, 32'h1234_5678, g);
        check_eq("rd_grant", g,        2'b10);
        check_eq("rd_we",    wb_we_o,  1'b0);
        check_eq("rd_done",  req_done, 2'b10);
        check_eq("rd_err",   req_err,  2'b00);
        check_eq("rd_data",  req_data_rd[DW +: DW], 32'h1234_5678);
        repeat (3) tick();
        check_eq("rd_hold",  req_data_rd[DW +: DW], 32'h1234_5678);

        // Simultaneous starts alternate ownership
        d0 = done_cnt;
        for (int r = 0; r < 4; r++) begin
            tick();
            set_cmd(0, 32'h9000_0100 + 32'(r), 4'h3, 1'b0, 32'h0);
            set_cmd(1, 32'h9000_0200 + 32'(r), 4'hC, 1'b0, 32'h0);
            issue(2'b11);
            slave(K_ACK, 0, 32'h4000_0000 + 32'(r), g);
            check_eq("rr_grant0", g,        2'b01);
            check_eq("rr_done0",  req_done, 2'b01);
            check_eq("rr_rd0",    req_data_rd[0 +: DW], 32'h4000_0000 + 32'(r));
            slave(K_ACK, 1, 32'h5000_0000 + 32'(r), g);
            check_eq("rr_grant1", g,        2'b10);
            check_eq("rr_done1",  req_done, 2'b10);
            check_eq("rr_rd1",    req_data_rd[DW +: DW], 32'h5000_0000 + 32'(r));
        end
        tick();
        check_eq("rr_done_count", done_cnt - d0, 8);

        // Three retries then ack: each rty leaves exactly one idle cycle
        tick();
        set_cmd(0, 32'h9000_0008, 4'hF, 1'b1, 32'hCAFE_0001);
        issue(2'b01);
        wait_cyc(n);
        for (int k = 0; k < 3; k++) begin
            wb_rty_i = 1'b1;
            tick();
            wb_rty_i = 1'b0;
            check_eq("rty_gap", wb_cyc_o, 1'b0);
            wait_cyc(n);
            check_eq("rty_gap_len", n, 1);
        end
        check_eq("rty_adr_same", wb_adr_o, 32'h9000_0008);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check_eq("rty3_done", req_done, 2'b01);
        check_eq("rty3_err",  req_err,  2'b00);

        // Five retries exhaust the budget
        tick();
        issue(2'b01);
        wait_cyc(n);
        for (int k = 0; k < 4; k++) begin
            wb_rty_i = 1'b1;
            tick();
            wb_rty_i = 1'b0;
            check_eq("rty5_nodone", req_done, 2'b00);
            wait_cyc(n);
        end
        wb_rty_i = 1'b1;
        tick();
        wb_rty_i = 1'b0;
        check_eq("rty5_done", req_done, 2'b01);
        check_eq("rty5_err",  req_err,  2'b01);
        check_eq("rty5_cyc",  wb_cyc_o, 1'b0);

        // Error response leaves previous read data intact
        tick();
        set_cmd(1, 32'h9000_000C, 4'hF, 1'b0, 32'h0);
        issue(2'b10);
        slave(K_ERR, 1, 32'hBAD0_BAD0, g);
        check_eq("err_done", req_done, 2'b10);
        check_eq("err_flag", req_err,  2'b10);
        check_eq("err_rd_keep", req_data_rd[DW +: DW], 32'h5000_0003);

        // Responses while idle are ignored
        repeat (2) tick();
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_rty_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        check_eq("idle_resp_done", req_done, 2'b00);
        check_eq("idle_resp_cyc",  wb_cyc_o, 1'b0);

        // Restarts while active (and in the done cycle) are dropped
        c0 = cyc_rises;
        set_cmd(0, 32'h9000_0010, 4'h1, 1'b1, 32'h0000_0011);
        issue(2'b01);
        wait_cyc(n);
        issue(2'b01);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check_eq("busy_done", req_done, 2'b01);
        issue(2'b01);
        repeat (4) tick();
        check_eq("busy_one_cycle", cyc_rises - c0, 1);
        check_eq("busy_active",    req_active, 2'b00);

`ifdef WB_ARB_TIMEOUT_EN
        // Silent slave times out TIMEOUT cycles after the first BUS cycle
        issue(2'b01);
        wait_cyc(n);
        n = 0;
        while (!req_done[0] && n < 200) begin
            tick();
            n++;
        end
        check_eq("tmo_cycles", n, TMO);
        check_eq("tmo_err",    req_err, 2'b01);
        tick();
`endif

        // Asynchronous reset in the middle of a transfer
        set_cmd(0, 32'h9000_0020, 4'hF, 1'b0, 32'h0);
        set_cmd(1, 32'h9000_0024, 4'hF, 1'b0, 32'h0);
        issue(2'b11);
        wait_cyc(n);
`ifndef WB_ARB_TIMEOUT_EN
        repeat (80) tick();
        check_eq("no_tmo_cyc", wb_cyc_o, 1'b1);
`else
        repeat (2) tick();
`endif
        d0 = done_cnt;
        #1;
        wb_rst_n = 1'b0;
        #1;
        check_eq("arst_cyc",    wb_cyc_o,   1'b0);
        check_eq("arst_stb",    wb_stb_o,   1'b0);
        check_eq("arst_grant",  grant,      2'b00);
        check_eq("arst_active", req_active, 2'b00);
        tick();
        tick();
        #2;
        wb_rst_n = 1'b1;
        repeat (5) tick();
        check_eq("arst_no_pending", wb_cyc_o, 1'b0);
        check_eq("arst_no_done",    done_cnt - d0, 0);
        issue(2'b11);
        slave(K_ACK, 0, 32'h7777_0000, g);
        check_eq("arst_first_grant", g, 2'b01);
        slave(K_ACK, 0, 32'h7777_0001, g);
        check_eq("arst_second_grant", g, 2'b10);
        tick();
        check_eq("bus_invariants", bad_owner, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
